tdc_therm_decoder: RTL and testbench

//  Reader side of the ADPLL TDC delay line. The delay line is built from

---
 rtl/tdc_therm_decoder.sv | 74 +++++++
 tb/tb_tdc_therm_decoder.sv | 107 ++++++++++
 2 files changed

// File: rtl/tdc_therm_decoder.sv
// tdc_therm_decoder: converts sampled TDC delay-line taps into the first edge position.
// Three stages: polarity correction, single-tap bubble removal, priority encode.
module tdc_therm_decoder #(
    parameter int N_TAPS  = 16,
    parameter int OUT_W   = 4,
    parameter bit INV_ODD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_TAPS-1:0] tap_i,
    input  logic              valid_i,
    output logic [OUT_W-1:0]  pos_o,
    output logic              edge_pol_o,
    output logic              valid_o,
    output logic              no_edge_o,
    output logic              bubble_o
);
    localparam logic [N_TAPS-1:0] MASK = {(N_TAPS/2){2'b10}} & {N_TAPS{INV_ODD}};

    logic [N_TAPS-1:0] t1, c, c2;
    logic [N_TAPS+1:0] ext;
    logic              v1, v2, bub2, found;
    logic [OUT_W-1:0]  idx;

    // End taps are replicated so the majority vote can never flip them.
    assign ext = {t1[N_TAPS-1], t1, t1[0]};

    for (genvar i = 0; i < N_TAPS; i++) begin : g_maj
        assign c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end

    // Downward scan so the lowest differing tap wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_TAPS - 1; i >= 1; i--) begin
            if (c2[i] != c2[0]) begin
                found = 1'b1;
                idx   = i[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1         <= '0;
            v1         <= 1'b0;
            c2         <= '0;
            bub2       <= 1'b0;
            v2         <= 1'b0;
            pos_o      <= '0;
            edge_pol_o <= 1'b0;
            no_edge_o  <= 1'b0;
            bubble_o   <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            v1      <= valid_i & en;
            v2      <= v1 & en;
            valid_o <= v2 & en;
            if (valid_i && en) t1 <= tap_i ^ MASK;
            if (v1 && en) begin
                c2   <= c;
                bub2 <= |(c ^ t1);
            end
            if (v2 && en) begin
                pos_o      <= found ? idx : pos_o;
                no_edge_o  <= ~found;
                edge_pol_o <= c2[0];
                bubble_o   <= bub2;
            end
        end
    end
endmodule

// File: tb/tb_tdc_therm_decoder.sv
// tb_tdc_therm_decoder: directed vectors for the TDC thermometer decoder.
module tb_tdc_therm_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] tap = '0;
    logic        valid_in = 1'b0;
    logic [3:0]  pos;
    logic        edge_pol, valid_out, no_edge, bubble;
    int          errors = 0;
    int          checks = 0;

    tdc_therm_decoder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tap_i(tap), .valid_i(valid_in),
        .pos_o(pos), .edge_pol_o(edge_pol), .valid_o(valid_out),
        .no_edge_o(no_edge), .bubble_o(bubble)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-sample transaction: present at an edge, expect the strobe after the third edge.
    task automatic run(input string tag, input logic [15:0] raw, input logic [3:0] epos,
                       input logic epol, input logic ebub, input logic enone);
        tap = raw; valid_in = 1'b1; en = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        check({tag, "_early"}, 16'(valid_out), 16'd0);
        tick();
        check({tag, "_valid"}, 16'(valid_out), 16'd1);
        check({tag, "_pos"}, 16'(pos), 16'(epos));
        check({tag, "_pol"}, 16'(edge_pol), 16'(epol));
        check({tag, "_bub"}, 16'(bubble), 16'(ebub));
        check({tag, "_none"}, 16'(no_edge), 16'(enone));
        tick();
        check({tag, "_strobe1"}, 16'(valid_out), 16'd0);
    endtask

    logic [15:0] s_tap [8];
    logic        s_val [8];
    logic        s_en  [8];
    logic        s_exp [8];
    logic [3:0]  s_pos [8];

    initial begin
        #12;
        check("rst_valid", 16'(valid_out), 16'd0);
        check("rst_pos", 16'(pos), 16'd0);
        check("rst_flags", {13'd0, edge_pol, no_edge, bubble}, 16'd0);
        rst_n = 1'b1;
        tick();
        run("t1", 16'hAA55, 4'd8, 1'b1, 1'b0, 1'b0);
        run("t4", 16'h5555, 4'd8, 1'b1, 1'b0, 1'b1);
        run("t2", 16'h555A, 4'd4, 1'b0, 1'b0, 1'b0);
        run("t3", 16'hAA5D, 4'd8, 1'b1, 1'b1, 1'b0);
        run("dbl", 16'hAA4D, 4'd3, 1'b1, 1'b0, 1'b0);
        run("last", 16'hD555, 4'd15, 1'b1, 1'b0, 1'b0);
        run("first", 16'h5554, 4'd1, 1'b0, 1'b0, 1'b0);
        run("tap0", 16'hAAAB, 4'd1, 1'b1, 1'b0, 1'b0);

        // en low alongside the second sample flushes the first two; the last two emerge.
        s_tap = '{16'h5555, 16'hAA4D, 16'hAA55, 16'h555A, 0, 0, 0, 0};
        s_val = '{1, 1, 1, 1, 0, 0, 0, 0};
        s_en  = '{1, 0, 1, 1, 1, 1, 1, 1};
        s_exp = '{0, 0, 0, 0, 1, 1, 0, 0};
        s_pos = '{0, 0, 0, 0, 8, 4, 0, 0};
        for (int k = 0; k < 8; k++) begin
            tap = s_tap[k]; valid_in = s_val[k]; en = s_en[k];
            tick();
            check($sformatf("en_valid%0d", k), 16'(valid_out), 16'(s_exp[k]));
            if (s_exp[k]) check($sformatf("en_pos%0d", k), 16'(pos), 16'(s_pos[k]));
        end

        // Async reset with a sample in flight.
        tap = 16'hAA5D; valid_in = 1'b1; en = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", 16'(valid_out), 16'd0);
        check("arst_pos", 16'(pos), 16'd0);
        check("arst_flags", {13'd0, edge_pol, no_edge, bubble}, 16'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("arst_stale%0d", k), 16'(valid_out), 16'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
